// File: rtl/dpram_access_arbiter_pkg.sv
// dpram_access_arbiter_pkg: shared width helpers and default geometry for the banked DPRAM arbiter.
package dpram_access_arbiter_pkg;
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_RAM_WIDTH = 64;
    localparam int DEF_ADDR_SIZE = 10;
    localparam int DEF_NUM_BANKS = 4;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Request address is {bank, word}: the bank field sits directly above the word field.
    function automatic int addr_width(input int bank_bits, input int word_bits);
        return bank_bits + word_bits;
    endfunction

    localparam int DEF_BANK_BITS = id_width(DEF_NUM_BANKS);
    localparam int DEF_ID_BITS   = id_width(DEF_NUM_REQ);
endpackage

// File: rtl/dpram_access_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a one-hot grant; priority starts just after the last winner.
module rr_arbiter
    import dpram_access_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = id_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] ptr;
    logic [IW-1:0] cand;
    logic          hit;

    // Walk requesters from ptr with explicit wrap so unused codes never appear for odd N.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        hit  = 1'b0;
        cand = ptr;
        for (int k = 0; k < N; k++) begin
            if (rst_n && !hit && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = cand;
                hit       = 1'b1;
            end
            cand = (cand == IW'(N - 1)) ? '0 : cand + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (hit)
            ptr <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
    end
endmodule

// File: rtl/dpram_access_arbiter.sv
// dpram_access_arbiter: round-robin sharing of a banked dual-port memory, with a fixed
// 3-cycle read response pipeline tagged by requester ID.
module dpram_access_arbiter
    import dpram_access_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int RAM_WIDTH = DEF_RAM_WIDTH,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int BANK_BITS = DEF_BANK_BITS,
    parameter int ID_BITS   = DEF_ID_BITS
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [NUM_REQ-1:0]                          req_wr,
    input  logic [NUM_REQ*(BANK_BITS+ADDR_SIZE)-1:0]    req_wr_addr,
    input  logic [NUM_REQ*RAM_WIDTH-1:0]                req_wr_data,
    output logic [NUM_REQ-1:0]                          gnt_wr,
    input  logic [NUM_REQ-1:0]                          req_rd,
    input  logic [NUM_REQ*(BANK_BITS+ADDR_SIZE)-1:0]    req_rd_addr,
    output logic [NUM_REQ-1:0]                          gnt_rd,
    output logic                                        rsp_valid,
    output logic [ID_BITS-1:0]                          rsp_id,
    output logic [RAM_WIDTH-1:0]                        rsp_data,
    output logic [NUM_BANKS-1:0]                        mem_wr_en,
    output logic [NUM_BANKS-1:0]                        mem_rd_en,
    output logic                                        write,
    output logic                                        read,
    output logic [ADDR_SIZE-1:0]                        wr_address,
    output logic [ADDR_SIZE-1:0]                        rd_address,
    output logic [RAM_WIDTH-1:0]                        data_in,
    input  logic [NUM_BANKS*RAM_WIDTH-1:0]              bank_dout,
    input  logic [NUM_BANKS-1:0]                        bank_dvalid
);
    localparam int AW = addr_width(BANK_BITS, ADDR_SIZE);

    logic [ID_BITS-1:0]   wr_idx, rd_idx;
    logic [AW-1:0]        wr_a, rd_a;
    logic [RAM_WIDTH-1:0] wr_d;
    logic                 wr_go, rd_go;
    logic                 rd_v1, rd_v2;
    logic [ID_BITS-1:0]   rd_id1, rd_id2;
    logic [BANK_BITS-1:0] rd_bank1, rd_bank2;
    logic                 dvalid_unused;

    rr_arbiter #(.N(NUM_REQ), .IW(ID_BITS)) u_wr_arb (
        .clk(clk), .rst_n(rst_n), .req(req_wr), .gnt(gnt_wr), .idx(wr_idx)
    );

    rr_arbiter #(.N(NUM_REQ), .IW(ID_BITS)) u_rd_arb (
        .clk(clk), .rst_n(rst_n), .req(req_rd), .gnt(gnt_rd), .idx(rd_idx)
    );

    assign wr_go = |gnt_wr;
    assign rd_go = |gnt_rd;
    assign wr_a  = req_wr_addr[int'(wr_idx)*AW +: AW];
    assign rd_a  = req_rd_addr[int'(rd_idx)*AW +: AW];
    assign wr_d  = req_wr_data[int'(wr_idx)*RAM_WIDTH +: RAM_WIDTH];

    // Latency is fixed, so the tracked bank index selects the data and bank_dvalid is not needed.
    assign dvalid_unused = |bank_dvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write      <= 1'b0;
            read       <= 1'b0;
            mem_wr_en  <= '0;
            mem_rd_en  <= '0;
            wr_address <= '0;
            rd_address <= '0;
            data_in    <= '0;
            rd_v1      <= 1'b0;
            rd_v2      <= 1'b0;
            rd_id1     <= '0;
            rd_id2     <= '0;
            rd_bank1   <= '0;
            rd_bank2   <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
        end else begin
            write     <= wr_go;
            read      <= rd_go;
            mem_wr_en <= wr_go ? NUM_BANKS'(1) << wr_a[AW-1 -: BANK_BITS] : '0;
            mem_rd_en <= rd_go ? NUM_BANKS'(1) << rd_a[AW-1 -: BANK_BITS] : '0;
            if (wr_go) begin
                wr_address <= wr_a[ADDR_SIZE-1:0];
                data_in    <= wr_d;
            end
            if (rd_go)
                rd_address <= rd_a[ADDR_SIZE-1:0];
            rd_v1     <= rd_go;
            rd_id1    <= rd_idx;
            rd_bank1  <= rd_a[AW-1 -: BANK_BITS];
            rd_v2     <= rd_v1;
            rd_id2    <= rd_id1;
            rd_bank2  <= rd_bank1;
            rsp_valid <= rd_v2;
            if (rd_v2) begin
                rsp_id   <= rd_id2;
                rsp_data <= bank_dout[int'(rd_bank2)*RAM_WIDTH +: RAM_WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_dpram_access_arbiter.sv
// tb_dpram_access_arbiter: directed and random checks of arbitration, bank decode and read
// latency against a queue-based reference model and a simple banked memory stand-in.
module tb_dpram_access_arbiter;
    localparam int NR = 4;
    localparam int W  = 64;
    localparam int AS = 10;
    localparam int NB = 4;
    localparam int AW = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_wr, req_rd, gnt_wr, gnt_rd;
    logic [NR*AW-1:0]  req_wr_addr, req_rd_addr;
    logic [NR*W-1:0]   req_wr_data;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_data;
    logic [NB-1:0]     mem_wr_en, mem_rd_en;
    logic              write, read;
    logic [AS-1:0]     wr_address, rd_address;
    logic [W-1:0]      data_in;
    logic [NB*W-1:0]   bank_dout = '0;
    logic [NB-1:0]     bank_dvalid = '0;

    dpram_access_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_wr(req_wr), .req_wr_addr(req_wr_addr), .req_wr_data(req_wr_data), .gnt_wr(gnt_wr),
        .req_rd(req_rd), .req_rd_addr(req_rd_addr), .gnt_rd(gnt_rd),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .write(write), .read(read),
        .wr_address(wr_address), .rd_address(rd_address), .data_in(data_in),
        .bank_dout(bank_dout), .bank_dvalid(bank_dvalid)
    );

    always #5 clk = ~clk;

    // Memory stand-in: one-cycle registered read, read-before-write on the same edge.
    logic [W-1:0] mem [NB][1024];
    logic         mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int b = 0; b < NB; b++)
                for (int a = 0; a < 1024; a++)
                    mem[b][a] <= '0;
            mem_init <= 1'b1;
        end
        for (int b = 0; b < NB; b++) begin
            bank_dvalid[b] <= read && mem_rd_en[b];
            if (read && mem_rd_en[b])
                bank_dout[b*W +: W] <= mem[b][rd_address];
            if (write && mem_wr_en[b])
                mem[b][wr_address] <= data_in;
        end
    end

    typedef struct {
        int           due;
        int           id;
        logic [W-1:0] d;
    } rsp_t;

    int           cyc = 0, errors = 0, checks = 0;
    int           wp = 0, rp = 0, last_gw = -1, last_gr = -1;
    logic [W-1:0] shadow [4096];
    rsp_t         exq[$];
    logic         pw = 1'b0, pr = 1'b0;
    logic [AW-1:0] pwa = '0, pra = '0;
    logic [W-1:0] pwd = '0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic all_zero();
        check("rst_gnt_wr", gnt_wr, 0);
        check("rst_gnt_rd", gnt_rd, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_mem_wr_en", mem_wr_en, 0);
        check("rst_mem_rd_en", mem_rd_en, 0);
        check("rst_write", write, 0);
        check("rst_read", read, 0);
        check("rst_wr_address", wr_address, 0);
        check("rst_rd_address", rd_address, 0);
        check("rst_data_in", data_in, 0);
    endtask

    task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [W-1:0] d);
        req_wr[i] = 1'b1;
        req_wr_addr[i*AW +: AW] = a;
        req_wr_data[i*W +: W] = d;
    endtask

    task automatic set_rd(input int i, input logic [AW-1:0] a);
        req_rd[i] = 1'b1;
        req_rd_addr[i*AW +: AW] = a;
    endtask

    // One clock of reference model: first requester at or after the pointer wins; reads see
    // memory as it was before this cycle's write and answer 3 cycles after their grant.
    task automatic tick();
        logic [NR-1:0] ew, er;
        int gw, gr;
        @(negedge clk);
        if (!rst_n) begin
            wp = 0; rp = 0; pw = 1'b0; pr = 1'b0;
            exq.delete();
        end
        gw = -1; gr = -1;
        if (rst_n)
            for (int k = 0; k < NR; k++) begin
                if (gw < 0 && req_wr[(wp + k) % NR]) gw = (wp + k) % NR;
                if (gr < 0 && req_rd[(rp + k) % NR]) gr = (rp + k) % NR;
            end
        ew = '0; er = '0;
        if (gw >= 0) ew[gw] = 1'b1;
        if (gr >= 0) er[gr] = 1'b1;
        check("gnt_wr", gnt_wr, ew);
        check("gnt_rd", gnt_rd, er);
        check("write", write, pw);
        check("read", read, pr);
        check("mem_wr_en", mem_wr_en, pw ? 64'(1) << pwa[11:10] : 64'(0));
        check("mem_rd_en", mem_rd_en, pr ? 64'(1) << pra[11:10] : 64'(0));
        if (pw) begin
            check("wr_address", wr_address, pwa[9:0]);
            check("data_in", data_in, pwd);
        end
        if (pr) check("rd_address", rd_address, pra[9:0]);
        if (exq.size() > 0 && exq[0].due == cyc) begin
            check("rsp_valid", rsp_valid, 1);
            check("rsp_id", rsp_id, exq[0].id);
            check("rsp_data", rsp_data, exq[0].d);
            void'(exq.pop_front());
        end else
            check("rsp_valid_idle", rsp_valid, 0);
        pw = (gw >= 0);
        pr = (gr >= 0);
        if (gr >= 0) begin
            pra = req_rd_addr[gr*AW +: AW];
            exq.push_back('{cyc + 3, gr, shadow[pra]});
            rp = (gr + 1) % NR;
        end
        if (gw >= 0) begin
            pwa = req_wr_addr[gw*AW +: AW];
            pwd = req_wr_data[gw*W +: W];
            shadow[pwa] = pwd;
            wp = (gw + 1) % NR;
        end
        last_gw = gw;
        last_gr = gr;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) shadow[a] = '0;
        rst_n = 1'b0;
        req_wr_data = '0;
        req_wr_addr = '0;
        req_rd_addr = '0;
        for (int n = 0; n < 3; n++) begin
            req_wr = 4'($urandom);
            req_rd = 4'($urandom);
            for (int i = 0; i < NR; i++) begin
                req_wr_addr[i*AW +: AW] = 12'($urandom);
                req_rd_addr[i*AW +: AW] = 12'($urandom);
            end
            #1;
            all_zero();
            tick();
        end

        rst_n = 1'b1;
        req_wr = '0;
        req_rd = 4'b1111;
        #1;
        check("first_gnt_rd", gnt_rd, 4'b0001);
        tick();
        req_rd = '0;

        for (int i = 0; i < NR; i++) set_wr(i, {2'(i), 10'(12'h100 + i)}, 64'hA0 + 64'(i));
        for (int n = 0; n < 8; n++) begin
            #1;
            check("rr_gnt_wr", gnt_wr, 4'b0001 << (n % 4));
            tick();
        end
        req_wr = '0;

        set_wr(2, 12'h7FF, 64'hDEAD_BEEF);
        tick();
        req_wr = '0;
        check("wr_bank_en", mem_wr_en, 4'b0010);
        check("wr_addr_3ff", wr_address, 10'h3FF);
        set_rd(1, 12'h7FF);
        tick();
        req_rd = '0;
        tick();
        tick();
        check("rd_lat_valid", rsp_valid, 1);
        check("rd_lat_id", rsp_id, 1);
        check("rd_lat_data", rsp_data, 64'hDEAD_BEEF);
        tick();

        set_wr(0, 12'h010, 64'h1111_0000_AAAA_0000);
        tick();
        req_wr = '0;
        set_wr(3, 12'hC20, 64'h3333_0000_CCCC_0000);
        tick();
        req_wr = '0;
        set_rd(0, 12'h010);
        tick();
        req_rd = '0;
        set_rd(3, 12'hC20);
        tick();
        req_rd = '0;
        tick();
        check("b2b_id0", rsp_id, 0);
        check("b2b_data0", rsp_data, 64'h1111_0000_AAAA_0000);
        tick();
        check("b2b_valid1", rsp_valid, 1);
        check("b2b_id3", rsp_id, 3);
        check("b2b_data3", rsp_data, 64'h3333_0000_CCCC_0000);
        tick();

        set_wr(1, 12'h005, 64'h1);
        tick();
        req_wr = '0;
        tick();
        set_wr(2, 12'h005, 64'h2);
        set_rd(0, 12'h005);
        tick();
        req_wr = '0;
        req_rd = '0;
        tick();
        tick();
        check("rw_same_old", rsp_data, 64'h1);
        tick();
        set_rd(3, 12'h005);
        tick();
        req_rd = '0;
        tick();
        tick();
        check("rw_later_new", rsp_data, 64'h2);
        tick();

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_wr[i] && $urandom_range(1) == 1)
                    set_wr(i, {2'($urandom_range(3)), 10'($urandom_range(7))}, {$urandom, $urandom});
                if (!req_rd[i] && $urandom_range(1) == 1)
                    set_rd(i, {2'($urandom_range(3)), 10'($urandom_range(7))});
            end
            tick();
            if (last_gw >= 0) req_wr[last_gw] = 1'b0;
            if (last_gr >= 0) req_rd[last_gr] = 1'b0;
        end
        req_wr = '0;
        req_rd = '0;
        repeat (6) tick();
        check("drain_empty", 64'(exq.size()), 0);

        set_wr(1, 12'h456, 64'h55);
        tick();
        req_wr = '0;
        set_rd(0, 12'h123);
        tick();
        req_rd = '0;
        set_rd(2, 12'h456);
        tick();
        req_rd = '0;
        rst_n = 1'b0;
        #1;
        all_zero();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) set_wr(i, {2'(i), 10'h1}, 64'(i));
        #1;
        check("restart_gnt_wr", gnt_wr, 4'b0001);
        for (int n = 0; n < 4; n++) begin
            tick();
            check("no_rsp_after_rst", rsp_valid, 0);
        end
        req_wr = '0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
